instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 173 +++++++++++++++++
 tb/tb_instr_mem_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Serial boot loader: receives a length-prefixed little-endian image byte stream, writes it
// word by word into instruction memory, verifies an XOR checksum and releases the core reset.
module instr_mem_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_byte_in,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_err
);

    // state | meaning
    // LEN   | collecting the 4-byte word count
    // DATA  | collecting payload words, one memory write per word
    // CSUM  | waiting for the checksum byte
    // DONE  | image valid, core released
    // ERR   | oversize image or checksum mismatch, core held
    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] LP_MAX_WORDS = 32'(MAX_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_len;
    logic [31:0] r_word;
    logic [31:0] r_word_idx;
    logic [7:0]  r_csum;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_cpu_rst;

    logic        w_ready;
    logic        w_xfer;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_restart;
    logic [4:0]  w_lane;
    logic [31:0] w_len_full;
    logic [31:0] w_word_full;

    assign w_xfer      = i_byte_valid & w_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    assign w_last_word = (r_word_idx == (r_len - 32'd1));
    assign w_restart   = i_start & ((r_state == S_DONE) | (r_state == S_ERR));
    assign w_lane      = {r_byte_cnt, 3'b000};
    // The 4th byte is still on the input, so finish the word combinationally for the decisions.
    assign w_len_full  = {i_byte_in, r_len[23:0]};
    assign w_word_full = {i_byte_in, r_word[23:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        o_done  = 1'b0;
        o_err   = 1'b0;
        case (r_state)
            S_LEN: begin
                w_ready = 1'b1;
                if (w_xfer && w_last_byte) begin
                    if (w_len_full > LP_MAX_WORDS) begin
                        w_next = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_next = S_CSUM;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                w_ready = 1'b1;
                if (w_xfer && w_last_byte && w_last_word) begin
                    w_next = S_CSUM;
                end
            end
            S_CSUM: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    w_next = (i_byte_in == r_csum) ? S_DONE : S_ERR;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                if (i_start) begin
                    w_next = S_LEN;
                end
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_start) begin
                    w_next = S_LEN;
                end
            end
            default: begin
                w_next = S_LEN;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt  <= 2'd0;
            r_len       <= 32'd0;
            r_word      <= 32'd0;
            r_word_idx  <= 32'd0;
            r_csum      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= 1'b1;
        end else begin
            r_mem_we  <= 1'b0;
            // Registered from the next state so the release lands in the first DONE cycle.
            r_cpu_rst <= (w_next != S_DONE);
            if (w_restart) begin
                r_byte_cnt <= 2'd0;
                r_len      <= 32'd0;
                r_word     <= 32'd0;
                r_word_idx <= 32'd0;
                r_csum     <= 8'd0;
            end else if (w_xfer) begin
                case (r_state)
                    S_LEN: begin
                        r_len[w_lane +: 8] <= i_byte_in;
                        r_byte_cnt         <= r_byte_cnt + 2'd1;
                    end
                    S_DATA: begin
                        r_word[w_lane +: 8] <= i_byte_in;
                        r_csum              <= r_csum ^ i_byte_in;
                        r_byte_cnt          <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx;
                            r_mem_wdata <= w_word_full;
                            r_word_idx  <= r_word_idx + 32'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_byte_ready = w_ready;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_cpu_rst    = r_cpu_rst;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed and random images checked against an
// image-level reference model (parse length, words, XOR checksum).
module tb_instr_mem_loader;

    typedef logic [7:0] bq_t[$];

    localparam int MAXW = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_mis = 0;
    int we_total = 0;

    instr_mem_loader #(.MAX_WORDS(MAXW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_byte_in    (byte_in),
        .i_byte_valid (byte_valid),
        .o_byte_ready (byte_ready),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_cpu_rst    (cpu_rst),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":byte_ready"}, 32'(byte_ready), 32'd1);
        check({tag, ":cpu_rst"},    32'(cpu_rst),    32'd1);
        check({tag, ":mem_we"},     32'(mem_we),     32'd0);
        check({tag, ":mem_addr"},   mem_addr,        32'd0);
        check({tag, ":mem_wdata"},  mem_wdata,       32'd0);
        check({tag, ":done"},       32'(done),       32'd0);
        check({tag, ":err"},        32'(err),        32'd0);
    endtask

    // Offer one byte, optionally after idle gaps; acc reports whether it was taken.
    task automatic send_byte(input logic [7:0] b, input int gap_pct, output bit acc);
        for (int g = 0; g < 6 && gap_pct > 0 && $urandom_range(99, 0) < gap_pct; g++) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            @(posedge clk); #1;
        end
        byte_valid = 1'b1;
        byte_in    = b;
        @(negedge clk);
        acc = byte_ready;
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({tag, ":ready"},   32'(byte_ready), 32'd1);
        check({tag, ":done"},    32'(done),       32'd0);
        check({tag, ":err"},     32'(err),        32'd0);
        check({tag, ":cpu_rst"}, 32'(cpu_rst),    32'd1);
        @(posedge clk); #1;
    endtask

    function automatic bq_t mk_image(input int n, input bit good);
        bq_t q;
        logic [31:0] nl;
        logic [7:0]  cs;
        logic [7:0]  b;
        nl = 32'(n);
        cs = 8'd0;
        q.push_back(nl[7:0]);
        q.push_back(nl[15:8]);
        q.push_back(nl[23:16]);
        q.push_back(nl[31:24]);
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            q.push_back(b);
        end
        q.push_back(good ? cs : cs ^ 8'($urandom_range(255, 1)));
        return q;
    endfunction

    // Drive an image and check every write and the final outcome against the model.
    task automatic run_image(input string tag, input bq_t img, input int gap_pct, input int start_at);
        logic [31:0] n;
        logic [31:0] exp_words[$];
        logic [31:0] w;
        logic [7:0]  cs;
        bit          exp_done;
        int          consumed;
        int          base;
        int          widx;
        bit          acc;
        n = {img[3], img[2], img[1], img[0]};
        cs = 8'd0;
        exp_done = 1'b0;
        if (n > 32'(MAXW)) begin
            consumed = 4;
        end else begin
            for (int k = 0; k < int'(n); k++) begin
                w = {img[4 + 4 * k + 3], img[4 + 4 * k + 2], img[4 + 4 * k + 1], img[4 + 4 * k]};
                exp_words.push_back(w);
                cs ^= w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            end
            consumed = 4 + 4 * int'(n) + 1;
            exp_done = (img[consumed - 1] == cs);
        end
        base = we_total;
        widx = 0;
        for (int i = 0; i < img.size(); i++) begin
            if (i == start_at) start = 1'b1;
            send_byte(img[i], gap_pct, acc);
            start = 1'b0;
            check({tag, ":accept"}, 32'(acc), 32'(i < consumed));
            if (acc && i >= 4 && i < consumed - 1 && ((i - 4) % 4 == 3)) begin
                check({tag, ":we"},    32'(mem_we), 32'd1);
                check({tag, ":addr"},  mem_addr,    32'(widx));
                check({tag, ":wdata"}, mem_wdata,   exp_words[widx]);
                widx++;
            end
        end
        @(negedge clk);
        check({tag, ":nwrites"}, 32'(we_total - base), 32'(exp_words.size()));
        check({tag, ":done"},    32'(done),       32'(exp_done));
        check({tag, ":err"},     32'(err),        32'(!exp_done));
        check({tag, ":cpu_rst"}, 32'(cpu_rst),    32'(!exp_done));
        check({tag, ":ready"},   32'(byte_ready), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        bq_t img;
        bq_t img_b;
        bit  acc;
        int  base;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Payload XOR of this image is 0x02, so 0x02 loads and 0x01 is rejected.
        img = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h33, 8'hC0, 8'h62, 8'h00,
                8'h33, 8'hC2, 8'h62, 8'h00, 8'h02};
        run_image("nominal", img, 0, -1);
        check("nominal:word0_const", mem_addr, 32'd1);
        check("nominal:word1_const", mem_wdata, 32'h0062C233);

        do_start("start_done");
        img[12] = 8'h01;
        run_image("bad_csum", img, 0, -1);
        do_start("start_err");

        img = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_image("oversize", img, 0, -1);
        do_start("start_over");

        run_image("n_max", mk_image(MAXW, 1'b1), 0, -1);
        do_start("start_max");

        img = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        run_image("empty_ok", img, 0, -1);
        do_start("start_empty");
        img[4] = 8'h5A;
        run_image("empty_bad", img, 0, -1);
        do_start("start_empty_bad");

        img_b = mk_image(3, 1'b1);
        run_image("gapfree3", img_b, 0, -1);
        do_start("start_g1");
        run_image("throttled3", img_b, 50, -1);
        do_start("start_g2");

        // A start pulse in the middle of DATA must not disturb the load.
        run_image("start_ignored", mk_image(2, 1'b1), 30, 6);
        do_start("start_g3");

        for (int t = 0; t < 6; t++) begin
            run_image($sformatf("rand%0d", t), mk_image($urandom_range(5, 1), t % 3 != 2),
                      $urandom_range(40, 0), -1);
            do_start($sformatf("rstart%0d", t));
        end

        img = mk_image(3, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], 0, acc);
            check("midword:accept", 32'(acc), 32'd1);
        end
        base = we_total;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midword_rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midword:no_we", 32'(we_total - base), 32'd0);
        check_reset_outputs("midword_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_image("after_rst", mk_image(3, 1'b1), 20, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
